// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the frame/oversample
// constants also used by the tick generator and the transmitter.
package uart_pkg;
  localparam int UART_OVER      = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side handshake between the UART receiver (master) and the core (slave).
interface uart_rx_oversample_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_error;
  logic                 overrun;

  modport master (output rx_data, rx_valid, frame_error, overrun, input rx_ack);
  modport slave  (input rx_data, rx_valid, frame_error, overrun, output rx_ack);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to 1 (idle-high lines).
module uart_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver driven by an OVER-x oversample tick; samples each bit at its
// centre and hands bytes to the core over a valid/ack handshake.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OVER      = UART_OVER
) (
  input  logic clk,
  input  logic reset_n,
  input  logic oversample_tick,
  input  logic rx,
  output logic busy,
  uart_rx_oversample_if.master rif
);
  localparam int TW = $clog2(OVER);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVER/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVER - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;
  uart_sync2 #(.WIDTH(1)) u_sync (.clk(clk), .reset_n(reset_n), .d(rx), .q(rx_s));

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;
  logic                 stop_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  // Everything advances on ticks only; stop_hit marks the stop-bit centre sample.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_hit   = 1'b0;
    if (oversample_tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
        START: if (tick_cnt_q == HALF_LAST) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
        DATA: if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
        STOP: if (tick_cnt_q == TICK_LAST) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          stop_hit   = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion in the ack cycle loads the new byte with no overrun.
  always_comb begin
    busy          = (state_q != IDLE);
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    if (rx_valid_q && rif.rx_ack) rx_valid_d = 1'b0;
    if (stop_hit) begin
      if (rx_s) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        overrun_d  = rx_valid_q && !rif.rx_ack;
      end else begin
        frame_error_d = 1'b1;
      end
    end
  end

  assign rif.rx_data     = rx_data_q;
  assign rif.rx_valid    = rx_valid_q;
  assign rif.frame_error = frame_error_q;
  assign rif.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: frames are serialised on rx, expected
// completions are queued and matched against the handshake outputs.
module tb_uart_rx_oversample;
  import uart_pkg::*;
  localparam int DB  = UART_DATA_BITS;
  localparam int OV  = UART_OVER;
  // clk edges from rx falling to rx_valid: 2 sync flops, detect tick, then the frame
  localparam int LAT = 3 + (DB + 1) * OV + OV / 2;

  typedef struct packed {
    logic          ferr;
    logic          ovr;
    logic          vld;
    logic [DB-1:0] data;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, rx = 1'b1, busy;
  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   tick_div = 1, tick_ct = 0;
  int   cyc = 0, t_fall = 0;
  bit   chk_lat = 1'b0;
  logic pv = 1'b0, pack = 1'b0;

  uart_rx_oversample_if #(.DATA_BITS(DB)) rif ();

  uart_rx_oversample #(.DATA_BITS(DB), .OVER(OV)) dut (
    .clk(clk), .reset_n(reset_n), .oversample_tick(tick), .rx(rx), .busy(busy), .rif(rif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_ct >= tick_div - 1) begin
      tick    = 1'b1;
      tick_ct = 0;
    end else begin
      tick = 1'b0;
      tick_ct++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic ferr, input logic ovr, input logic vld, input logic [DB-1:0] d);
    exp_t e;
    e.ferr = ferr; e.ovr = ovr; e.vld = vld; e.data = d;
    sb.push_back(e);
  endtask

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    rx = 1'b0;
    t_fall = cyc;
    tick_wait(OV);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      tick_wait(OV);
    end
    rx = stop;
    tick_wait(OV);
    rx = 1'b1;
  endtask

  task automatic ack_pulse();
    rif.rx_ack = 1'b1;
    @(negedge clk);
    rif.rx_ack = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    pack <= rif.rx_ack;
  end

  // A completion is any flag pulse, a valid rise, or valid surviving an ack.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (rif.frame_error || rif.overrun || (rif.rx_valid && (!pv || pack)))) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_error", 32'(rif.frame_error), 32'(e.ferr));
        chk("overrun",     32'(rif.overrun),     32'(e.ovr));
        chk("rx_valid",    32'(rif.rx_valid),    32'(e.vld));
        chk("rx_data",     32'(rif.rx_data),     32'(e.data));
        if (chk_lat) begin
          chk("latency", 32'(cyc - t_fall), 32'(LAT));
          chk_lat = 1'b0;
        end
      end
    end
    pv = rif.rx_valid && reset_n;
  end

  initial begin
    rif.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rif.rx_valid), 32'd0);
    chk("rst_data",  32'(rif.rx_data), 32'd0);
    chk("rst_ferr",  32'(rif.frame_error), 32'd0);
    chk("rst_ovr",   32'(rif.overrun), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic frame with latency check
    expect_ev(1'b0, 1'b0, 1'b1, 8'hA5);
    chk_lat = 1'b1;
    send_frame(8'hA5, 1'b1);
    chk("lat_seen", 32'(chk_lat), 32'd0);
    tick_wait(4);
    ack_pulse();
    @(negedge clk);
    chk("ack_clear", 32'(rif.rx_valid), 32'd0);

    // glitch reject
    rx = 1'b0;
    tick_wait(5);
    chk("glitch_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    tick_wait(12);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(rif.rx_valid), 32'd0);

    // frame error keeps old data, valid stays low
    expect_ev(1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(8'h3C, 1'b0);
    tick_wait(24);
    chk("ferr_idle", 32'(busy), 32'd0);
    chk("ferr_data", 32'(rif.rx_data), 32'hA5);

    // overrun on back-to-back frames with no ack
    expect_ev(1'b0, 1'b0, 1'b1, 8'h11);
    send_frame(8'h11, 1'b1);
    expect_ev(1'b0, 1'b1, 1'b1, 8'h22);
    send_frame(8'h22, 1'b1);
    tick_wait(4);
    ack_pulse();

    // ack in the exact completion cycle of the second byte
    expect_ev(1'b0, 1'b0, 1'b1, 8'h33);
    send_frame(8'h33, 1'b1);
    expect_ev(1'b0, 1'b0, 1'b1, 8'h44);
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        rif.rx_ack = 1'b1;
        @(negedge clk);
        rif.rx_ack = 1'b0;
      end
    join
    tick_wait(2);
    ack_pulse();
    @(negedge clk);
    chk("ack2_clear", 32'(rif.rx_valid), 32'd0);

    // sparse ticks: 50 MHz / 9600 baud / 16
    tick_div = 326;
    tick_wait(2);
    expect_ev(1'b0, 1'b0, 1'b1, 8'h5A);
    send_frame(8'h5A, 1'b1);
    tick_wait(4);

    // partial frame, then reset mid-DATA
    rx = 1'b0;
    tick_wait(OV);
    tick_wait(OV);
    rx = 1'b1;
    tick_wait(OV / 2);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rif.rx_valid), 32'd0);
    chk("arst_data",  32'(rif.rx_data), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_flags", 32'(rif.frame_error | rif.overrun), 32'd0);
    tick_div = 1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    expect_ev(1'b0, 1'b0, 1'b1, 8'hFF);
    send_frame(8'hFF, 1'b1);
    tick_wait(4);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receiver that consumes the 16x oversample tick from the team's baud/oversample tick generator and deserialises an asynchronous rx line into bytes. Format is 8N1, LSB first. It detects the start bit, samples each bit at its centre, and checks the stop bit. Received bytes go to the core through a valid/ack handshake, with frame-error and overrun flags.

Parameters:
DATA_BITS, 8, data bits per frame (5..9).
OVER, 16, oversample ticks per bit; must be even and >= 8.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
oversample_tick  input  1  1-cycle pulse at baud*OVER rate, from the tick generator
rx  input  1  asynchronous serial line, idle high
rx_ack  input  1  core accepts rx_data; sampled only while rx_valid=1
rx_data  output  DATA_BITS  last received byte, LSB = first bit on the line
rx_valid  output  1  level; high from frame completion until acked
frame_error  output  1  1-cycle pulse: stop bit sampled low
overrun  output  1  1-cycle pulse: new byte completed while rx_valid=1 and no ack in the same cycle
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift register=0.
  - Synchroniser flops = 1.
  - rx_data=0, rx_valid=0, frame_error=0, overrun=0, busy=0.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Tick gating: state, tick_cnt and bit_cnt advance only on cycles with oversample_tick=1. With no tick, everything holds.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt<=0.
- START: on each tick:
  - If tick_cnt==OVER/2-1: if rx_s=0, go to DATA with tick_cnt<=0 and bit_cnt<=0. Otherwise it is a glitch: go to IDLE with no flags.
  - Otherwise tick_cnt++.
  - Net effect: the start bit is checked OVER/2 ticks after the falling edge is seen, i.e. at the bit centre.
- DATA: on each tick:
  - If tick_cnt==OVER-1: shift rx_s in at the MSB, shifting right; tick_cnt<=0. If bit_cnt==DATA_BITS-1, go to STOP; else bit_cnt++.
  - Otherwise tick_cnt++.
- STOP: on the tick where tick_cnt==OVER-1, go to IDLE and:
  - rx_s=1: rx_data<=shift register; rx_valid<=1.
  - rx_s=0: frame_error<=1 for 1 cycle; rx_data and rx_valid unchanged.
- Early return: the FSM returns to IDLE mid-stop-bit, so back-to-back frames are received with no lost ticks.
- Latency: rx_valid rises on the clk edge after the tick that sampled the stop centre. That is (DATA_BITS+1)*OVER + OVER/2 ticks after start detection.
- Handshake:
  - rx_valid=1 and rx_ack=1 clears rx_valid on the next edge.
  - rx_ack while rx_valid=0 is ignored.
- Boundary cases:
  - Completion with rx_valid=1 and rx_ack=0: rx_data is overwritten, rx_valid stays 1, overrun pulses.
  - Completion in the same cycle as rx_ack=1: the new data is loaded, rx_valid stays 1, no overrun.
  - Frame error with rx_valid=1: only frame_error pulses; the old data is preserved.
  - frame_error and overrun are never high together.
  - Break condition (rx held low): the frame ends with frame_error, then the FSM waits in IDLE. It restarts at once if rx_s is still 0 (one frame_error per frame time). This behaviour is accepted.
  - Reset mid-frame: all state clears asynchronously; the partial byte is discarded.
- Widths:
  - tick_cnt is $clog2(OVER) bits; bit_cnt is $clog2(DATA_BITS) bits.
  - Comparisons use full-width constants.
  - No wrap beyond OVER-1 is possible.

Decomposition:
- Package uart_pkg holds:
  - The FSM state enum: IDLE, START, DATA, STOP (2-bit).
  - Constants UART_OVER=16 and UART_DATA_BITS=8, shared with the tick generator and the future transmitter.
- Sub-module uart_sync2: a 2-flop synchroniser with reset value 1, reused by other async inputs.

Test Plan:
- Basic frame: tick every cycle, OVER=16; send 0xA5 8N1 -> rx_data=0xA5, rx_valid=1 exactly 152 ticks (+2 cycles of sync delay) after the falling edge; frame_error=0.
- Glitch reject: rx low for 5 ticks then high -> FSM returns to IDLE at the 8th tick; no rx_valid, no flags.
- Frame error: send 0x3C with the stop bit low -> frame_error pulses 1 cycle; rx_valid stays 0; rx_data keeps its prior value.
- Overrun: send 0x11, then 0x22 back-to-back with no ack -> overrun pulses on the second completion; rx_data=0x22; rx_valid=1.
- Ack collision: assert rx_ack in the exact completion cycle of the second byte -> no overrun; rx_valid=1; rx_data=second byte.
- Sparse ticks and reset: ticks every 326 clocks (50 MHz / 9600 / 16); receive 0x5A correctly. Then drop reset_n mid-DATA -> all outputs go to 0 immediately; the next frame 0xFF is received cleanly.
